// File: rtl/sdram_sample_bridge.sv
// sdram_sample_bridge: per-audio-frame bridge from the loop controller to an
// Avalon-MM SDRAM slave. Each aud_clk rising edge starts a write and/or read
// transaction that honours waitrequest/readdatavalid; the read word is held
// on play_data. Dropped frames are reported through overrun/drop_count.
//
// Optional feature macro: SAMPLE_BRIDGE_TIMEOUT_EN
//   defined   - WAIT_DATA gives up after TIMEOUT cycles, returns a muted
//               sample and sets the sticky timeout_err flag.
//   undefined - WAIT_DATA waits indefinitely; timeout_err is tied low.

module sdram_sample_bridge #(
    parameter int unsigned ADDR_W  = 25,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aud_clk,
    input  logic              record,
    input  logic              play,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_write_n,
    output logic              avm_read_n,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] play_data,
    output logic              play_valid,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        drop_count,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StWaitData
    } state_e;

    // Frame tick: 2-flop synchronizer, edge register, registered pulse
    logic aud_s1_q, aud_s2_q, aud_s3_q;
    logic tick_d, tick_q;

    state_e state_d, state_q;

    // record only selects the entry state, so only play needs to be kept
    logic              req_play_d, req_play_q;
    logic [ADDR_W-1:0] avm_address_d, avm_address_q;
    logic [DATA_W-1:0] avm_writedata_d, avm_writedata_q;
    logic              avm_write_n_d, avm_write_n_q;
    logic              avm_read_n_d, avm_read_n_q;
    logic [DATA_W-1:0] play_data_d, play_data_q;
    logic              play_valid_d, play_valid_q;
    logic              busy_d, busy_q;
    logic              overrun_d, overrun_q;
    logic [7:0]        drop_count_d, drop_count_q;

`ifdef SAMPLE_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt_d, wait_cnt_q;
    logic       timeout_err_d, timeout_err_q;
`endif

    // Rising-edge detect on the synchronized frame clock
    always_comb begin
        tick_d = aud_s2_q & ~aud_s3_q;
    end

    // Synchronizer and tick registers
    always_ff @(posedge clk) begin
        if (reset) begin
            aud_s1_q <= 1'b0;
            aud_s2_q <= 1'b0;
            aud_s3_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            aud_s1_q <= aud_clk;
            aud_s2_q <= aud_s1_q;
            aud_s3_q <= aud_s2_q;
            tick_q   <= tick_d;
        end
    end

    // Next-state, request latch, drop accounting and registered outputs
    always_comb begin
        state_d         = state_q;
        req_play_d      = req_play_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        play_data_d     = play_data_q;
        play_valid_d    = 1'b0;
        overrun_d       = overrun_q;
        drop_count_d    = drop_count_q;
`ifdef SAMPLE_BRIDGE_TIMEOUT_EN
        wait_cnt_d      = wait_cnt_q;
        timeout_err_d   = timeout_err_q;
`endif

        // A tick during a transaction is dropped; the latched request stays
        if (tick_q && (state_q != StIdle)) begin
            overrun_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (tick_q) begin
                    avm_address_d   = address;
                    avm_writedata_d = writedata;
                    req_play_d      = play;
                    if (record) begin
                        state_d = StWrite;
                    end else if (play) begin
                        state_d = StRead;
                    end else if (play_data_q != '0) begin
                        // Mute the held sample when playback stops
                        play_data_d  = '0;
                        play_valid_d = 1'b1;
                    end
                end
            end

            StWrite: begin
                if (!avm_waitrequest) begin
                    state_d = req_play_q ? StRead : StIdle;
                end
            end

            StRead: begin
                if (!avm_waitrequest) begin
                    state_d = StWaitData;
`ifdef SAMPLE_BRIDGE_TIMEOUT_EN
                    wait_cnt_d = 8'd0;
`endif
                end
            end

            StWaitData: begin
                if (avm_readdatavalid) begin
                    play_data_d  = avm_readdata;
                    play_valid_d = 1'b1;
                    state_d      = StIdle;
`ifdef SAMPLE_BRIDGE_TIMEOUT_EN
                end else if (wait_cnt_q == TimeoutLast) begin
                    play_data_d   = '0;
                    play_valid_d  = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
`endif
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Strobes are decoded from the next state so they are registered
        avm_write_n_d = (state_d != StWrite);
        avm_read_n_d  = (state_d != StRead);
        busy_d        = (state_d != StIdle);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            req_play_q      <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_write_n_q   <= 1'b1;
            avm_read_n_q    <= 1'b1;
            play_data_q     <= '0;
            play_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
            overrun_q       <= 1'b0;
            drop_count_q    <= 8'd0;
        end else begin
            state_q         <= state_d;
            req_play_q      <= req_play_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            avm_write_n_q   <= avm_write_n_d;
            avm_read_n_q    <= avm_read_n_d;
            play_data_q     <= play_data_d;
            play_valid_q    <= play_valid_d;
            busy_q          <= busy_d;
            overrun_q       <= overrun_d;
            drop_count_q    <= drop_count_d;
        end
    end

`ifdef SAMPLE_BRIDGE_TIMEOUT_EN
    // Read-timeout counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q    <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign avm_address   = avm_address_q;
    assign avm_writedata = avm_writedata_q;
    assign avm_write_n   = avm_write_n_q;
    assign avm_read_n    = avm_read_n_q;
    assign play_data     = play_data_q;
    assign play_valid    = play_valid_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_sdram_sample_bridge.sv
// Directed testbench for sdram_sample_bridge: record, record+play with
// stalls, stray readdatavalid, mute on stop, overrun/saturation (or read
// timeout when SAMPLE_BRIDGE_TIMEOUT_EN is defined) and mid-write reset.

module tb_sdram_sample_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        aud_clk = 1'b0;
    logic        record = 1'b0;
    logic        play = 1'b0;
    logic [24:0] address = '0;
    logic [31:0] writedata = '0;
    logic [24:0] avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write_n;
    logic        avm_read_n;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] play_data;
    logic        play_valid;
    logic        busy;
    logic        overrun;
    logic [7:0]  drop_count;
    logic        timeout_err;

    sdram_sample_bridge #(
        .ADDR_W (25),
        .DATA_W (32),
        .TIMEOUT(10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .aud_clk          (aud_clk),
        .record           (record),
        .play             (play),
        .address          (address),
        .writedata        (writedata),
        .avm_address      (avm_address),
        .avm_writedata    (avm_writedata),
        .avm_write_n      (avm_write_n),
        .avm_read_n       (avm_read_n),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest  (avm_waitrequest),
        .play_data        (play_data),
        .play_valid       (play_valid),
        .busy             (busy),
        .overrun          (overrun),
        .drop_count       (drop_count),
        .timeout_err      (timeout_err)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Bus activity seen at each rising edge
    int          wr_acc = 0;
    int          rd_acc = 0;
    int          rd_cyc = 0;
    int          pv_cnt = 0;
    logic [31:0] mem_word = '0;

    always @(posedge clk) begin
        if (!reset) begin
            if (!avm_write_n && !avm_waitrequest) begin
                wr_acc++;
                mem_word = avm_writedata;
            end
            if (!avm_read_n) rd_cyc++;
            if (!avm_read_n && !avm_waitrequest) rd_acc++;
            if (play_valid) pv_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Guarantees a fresh aud_clk rising edge just after a clk edge
    task automatic frame_rise();
        aud_clk = 1'b0;
        repeat (4) step();
        aud_clk = 1'b1;
    endtask

    task automatic wait_strobe(input bit rd, output int cyc);
        cyc = 0;
        while (((rd ? avm_read_n : avm_write_n) == 1'b1) && (cyc < 40)) begin
            step();
            cyc++;
        end
    endtask

    int c;
    int wr0, rd0, rc0, pv0;
    bit stable;

    initial begin
        // Reset values
        repeat (3) step();
        check_eq("rst_write_n", 32'(avm_write_n), 32'd1);
        check_eq("rst_read_n", 32'(avm_read_n), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_play_data", play_data, 32'd0);
        check_eq("rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b0;
        step();

        // Record only
        record = 1'b1; play = 1'b0; address = 25'h10; writedata = 32'hDEADBEEF;
        wr0 = wr_acc; rc0 = rd_cyc;
        frame_rise();
        wait_strobe(1'b0, c);
        check_eq("rec_latency", 32'(c), 32'd4);
        check_eq("rec_addr", 32'(avm_address), 32'h10);
        check_eq("rec_data", avm_writedata, 32'hDEADBEEF);
        check_eq("rec_read_n", 32'(avm_read_n), 32'd1);
        check_eq("rec_busy", 32'(busy), 32'd1);
        step();
        check_eq("rec_write_done", 32'(avm_write_n), 32'd1);
        check_eq("rec_busy_done", 32'(busy), 32'd0);
        check_eq("rec_wr_count", 32'(wr_acc - wr0), 32'd1);
        check_eq("rec_no_read", 32'(rd_cyc - rc0), 32'd0);

        // Record and play with 5-cycle stalls in WRITE and READ
        record = 1'b1; play = 1'b1; address = 25'h20; writedata = 32'h12345678;
        avm_waitrequest = 1'b1;
        wr0 = wr_acc; rd0 = rd_acc; pv0 = pv_cnt;
        frame_rise();
        wait_strobe(1'b0, c);
        check_eq("rw_wr_latency", 32'(c), 32'd4);
        stable = 1'b1;
        repeat (4) begin
            step();
            if (avm_write_n !== 1'b0 || avm_read_n !== 1'b1 || avm_address !== 25'h20 ||
                avm_writedata !== 32'h12345678) stable = 1'b0;
        end
        check_eq("rw_wr_stable", 32'(stable), 32'd1);
        avm_waitrequest = 1'b0;
        step();
        avm_waitrequest = 1'b1;
        check_eq("rw_read_after_write", 32'(avm_read_n), 32'd0);
        check_eq("rw_write_released", 32'(avm_write_n), 32'd1);
        check_eq("rw_rd_addr", 32'(avm_address), 32'h20);
        stable = 1'b1;
        repeat (4) begin
            step();
            if (avm_read_n !== 1'b0 || avm_write_n !== 1'b1 || avm_address !== 25'h20)
                stable = 1'b0;
        end
        check_eq("rw_rd_stable", 32'(stable), 32'd1);
        avm_waitrequest = 1'b0;
        step();
        check_eq("rw_wait_read_n", 32'(avm_read_n), 32'd1);
        check_eq("rw_wait_busy", 32'(busy), 32'd1);
        step();
        avm_readdata = mem_word;
        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        check_eq("rw_play_valid", 32'(play_valid), 32'd1);
        check_eq("rw_play_data", play_data, 32'h12345678);
        check_eq("rw_busy_done", 32'(busy), 32'd0);
        step();
        check_eq("rw_valid_pulse", 32'(play_valid), 32'd0);
        check_eq("rw_data_held", play_data, 32'h12345678);
        check_eq("rw_pv_count", 32'(pv_cnt - pv0), 32'd1);
        check_eq("rw_wr_count", 32'(wr_acc - wr0), 32'd1);
        check_eq("rw_rd_count", 32'(rd_acc - rd0), 32'd1);

        // readdatavalid while idle is ignored
        pv0 = pv_cnt;
        avm_readdata = 32'hFFFFFFFF;
        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        step();
        check_eq("stray_rdv_data", play_data, 32'h12345678);
        check_eq("stray_rdv_pv", 32'(pv_cnt - pv0), 32'd0);

        // Mute on stop, then a second silent frame gives no pulse
        record = 1'b0; play = 1'b0;
        frame_rise();
        repeat (4) step();
        check_eq("mute_valid", 32'(play_valid), 32'd1);
        check_eq("mute_data", play_data, 32'd0);
        check_eq("mute_busy", 32'(busy), 32'd0);
        frame_rise();
        repeat (6) step();
        check_eq("mute_once", 32'(pv_cnt - pv0), 32'd1);

        // Play only; slave never returns data
        play = 1'b1; address = 25'h33;
        frame_rise();
        wait_strobe(1'b1, c);
        check_eq("play_latency", 32'(c), 32'd4);
        check_eq("play_no_write", 32'(avm_write_n), 32'd1);
        step();
`ifdef SAMPLE_BRIDGE_TIMEOUT_EN
        repeat (9) step();
        check_eq("to_not_yet", 32'(play_valid), 32'd0);
        check_eq("to_busy", 32'(busy), 32'd1);
        step();
        check_eq("to_valid", 32'(play_valid), 32'd1);
        check_eq("to_data", play_data, 32'd0);
        check_eq("to_err", 32'(timeout_err), 32'd1);
        check_eq("to_idle", 32'(busy), 32'd0);
`else
        repeat (1100) step();
        check_eq("ovr_still_busy", 32'(busy), 32'd1);
        address = 25'h44; play = 1'b0;
        frame_rise();
        repeat (4) step();
        check_eq("ovr_flag", 32'(overrun), 32'd1);
        check_eq("ovr_drop1", 32'(drop_count), 32'd1);
        check_eq("ovr_busy", 32'(busy), 32'd1);
        check_eq("ovr_addr_kept", 32'(avm_address), 32'h33);
        for (int i = 0; i < 260; i++) begin
            frame_rise();
            repeat (4) step();
        end
        check_eq("ovr_drop_sat", 32'(drop_count), 32'd255);
        avm_readdata = 32'h0BADF00D;
        avm_readdatavalid = 1'b1;
        step();
        avm_readdatavalid = 1'b0;
        check_eq("ovr_late_valid", 32'(play_valid), 32'd1);
        check_eq("ovr_late_data", play_data, 32'h0BADF00D);
        check_eq("ovr_sticky", 32'(overrun), 32'd1);
        check_eq("ovr_no_timeout", 32'(timeout_err), 32'd0);
`endif

        // Reset in the middle of a stalled write
        play = 1'b0; record = 1'b1; address = 25'h55; writedata = 32'hAAAA5555;
        avm_waitrequest = 1'b1;
        frame_rise();
        wait_strobe(1'b0, c);
        check_eq("mid_write_started", 32'(avm_write_n), 32'd0);
        step();
        step();
        aud_clk = 1'b0;
        reset = 1'b1;
        step();
        check_eq("mid_rst_write_n", 32'(avm_write_n), 32'd1);
        check_eq("mid_rst_read_n", 32'(avm_read_n), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_addr", 32'(avm_address), 32'd0);
        check_eq("mid_rst_wdata", avm_writedata, 32'd0);
        check_eq("mid_rst_play_data", play_data, 32'd0);
        check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
        check_eq("mid_rst_drop", 32'(drop_count), 32'd0);
        check_eq("mid_rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        record = 1'b0;
        repeat (6) step();
        check_eq("post_rst_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
